// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch front end.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One queue slot: fetch address in the upper half, instruction word in the lower.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular {pc, instr} store for fetched words; the head is visible the cycle after it is written.
module fetch_queue_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [2*XLEN-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [2*XLEN-1:0]           rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [2*XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              do_write;
    logic              do_read;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_COUNT);
    assign count    = count_reg;
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;
    assign rd_data  = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_write, do_read})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !flush && !reset) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: issues in-order word fetches, buffers responses, and drops stale data after redirects.
module fetch_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            pc_select_i,
    input  logic [XLEN-1:0] pc_branch_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_src_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] rsp_pc_reg;
    logic [XLEN-1:0] last_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_reg;

    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_full;
    fetch_entry_t    q_head;
    fetch_entry_t    q_wr;
    logic [CW:0]     in_flight;
    logic            grant;
    logic            pop;
    logic            write_rsp;
    logic [XLEN-1:0] head_pc;

    // Queue occupancy plus requests in flight bounds how much we may ask for.
    assign in_flight   = {1'b0, q_count} + {1'b0, outstanding_reg};
    assign imem_req_o  = !reset_i && !pc_select_i && (in_flight < DEPTH_LIMIT);
    assign imem_addr_o = fetch_pc_reg;
    assign grant       = imem_req_o && imem_gnt_i;

    assign valid_o   = !reset_i && !q_empty && !pc_select_i;
    assign pop       = valid_o && ready_i;
    assign write_rsp = !reset_i && !pc_select_i && imem_rvalid_i && (discard_reg == '0);

    assign q_wr.pc    = rsp_pc_reg;
    assign q_wr.instr = imem_rdata_i;

    fetch_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .reset   (reset_i),
        .flush   (pc_select_i),
        .wr_en   (write_rsp),
        .wr_data (q_wr),
        .rd_en   (pop),
        .rd_data (q_head),
        .empty   (q_empty),
        .full    (q_full),
        .count   (q_count)
    );

    // An empty queue presents a NOP and keeps the PC of the last instruction handed to decode.
    assign head_pc       = q_empty ? last_pc_reg : q_head.pc;
    assign instruction_o = q_empty ? NOP_INSTR : q_head.instr;
    assign pc_o          = head_pc;
    assign pc_src_o      = head_pc + 32'd4;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            last_pc_reg     <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            case ({grant, imem_rvalid_i})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase

            if (pc_select_i) begin
                // Everything still in flight belongs to the abandoned path.
                fetch_pc_reg <= word_align(pc_branch_i);
                rsp_pc_reg   <= word_align(pc_branch_i);
                discard_reg  <= outstanding_reg - CW'(imem_rvalid_i);
            end else begin
                if (grant) fetch_pc_reg <= fetch_pc_reg + 32'd4;
                if (imem_rvalid_i) begin
                    if (discard_reg != '0) discard_reg <= discard_reg - 1'b1;
                    else                   rsp_pc_reg  <= rsp_pc_reg + 32'd4;
                end
            end

            if (pop) last_pc_reg <= q_head.pc;
        end
    end

    // The request throttle makes a response into a full queue impossible.
    assert property (@(posedge clk_i) disable iff (reset_i) !(write_rsp && q_full));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a small in-order memory responder.
module tb_fetch_prefetch_queue;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        pc_select_i = 1'b0;
    logic [31:0] pc_branch_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] pc_src_o;

    int          tests = 0;
    int          fails = 0;
    int          ngrants = 0;
    bit          auto_rsp = 1'b1;
    logic [31:0] pend[$];

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pc_select_i   (pc_select_i),
        .pc_branch_i   (pc_branch_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .pc_src_o      (pc_src_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, advance, then model the memory.
    task automatic tick();
        bit          g;
        bit          r;
        logic [31:0] a;
        @(negedge clk_i);
        g = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        r = imem_rvalid_i;
        @(posedge clk_i);
        #1;
        if (r && pend.size() != 0) void'(pend.pop_front());
        if (g) begin
            pend.push_back(a);
            ngrants++;
            $display("[TB] grant addr=%h", a);
        end
        imem_rvalid_i = auto_rsp && (pend.size() != 0);
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0]) : 32'h0;
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        imem_gnt_i = 1'b0;
        ready_i    = 1'b1;
        auto_rsp   = 1'b1;
        while ((valid_o || pend.size() != 0 || imem_rvalid_i) && n < 20) begin
            tick();
            n++;
        end
        chk1({tag, "_drain_valid"}, valid_o, 1'b0);
        chk({tag, "_drain_pending"}, 32'(pend.size()), 32'd0);
    endtask

    initial begin
        // Reset
        #1;
        chk1("rst_req_during", imem_req_o, 1'b0);
        chk1("rst_valid_during", valid_o, 1'b0);
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        chk1("rst_req_after", imem_req_o, 1'b1);
        chk1("rst_valid_after", valid_o, 1'b0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc_src", pc_src_o, 32'h4);
        chk("rst_instr_nop", instruction_o, 32'h0000_0013);

        // Streaming: one-cycle responses, decode always ready
        imem_gnt_i = 1'b1;
        ready_i    = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("stream_addr_%0d", k), imem_addr_o, 32'(4 * k));
            if (k >= 2) begin
                chk1($sformatf("stream_valid_%0d", k), valid_o, 1'b1);
                chk($sformatf("stream_pc_%0d", k), pc_o, 32'(4 * (k - 2)));
                chk($sformatf("stream_src_%0d", k), pc_src_o, 32'(4 * (k - 1)));
                chk($sformatf("stream_instr_%0d", k), instruction_o, mem_word(32'(4 * (k - 2))));
            end
        end
        drain("stream");
        chk("empty_pc_hold", pc_o, 32'd20);
        chk("empty_src_hold", pc_src_o, 32'd24);
        chk("empty_nop", instruction_o, 32'h0000_0013);
        tick();
        chk1("nognt_req", imem_req_o, 1'b1);
        chk("nognt_addr_hold", imem_addr_o, 32'd24);

        // Back-pressure: queue fills, requests stop, one pop admits one grant
        ready_i    = 1'b0;
        imem_gnt_i = 1'b1;
        ngrants    = 0;
        for (int k = 0; k < 8; k++) tick();
        chk("bp_grants", 32'(ngrants), 32'd4);
        chk1("bp_req_off", imem_req_o, 1'b0);
        chk1("bp_valid", valid_o, 1'b1);
        chk("bp_head", pc_o, 32'd24);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        ngrants = 0;
        chk("bp_addr_next", imem_addr_o, 32'd40);
        for (int k = 0; k < 5; k++) tick();
        chk("bp_one_grant", 32'(ngrants), 32'd1);
        chk1("bp_req_off2", imem_req_o, 1'b0);
        chk("bp_head2", pc_o, 32'd28);

        // Reset mid-stream with three entries queued
        imem_gnt_i = 1'b0;
        ready_i    = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("mid_head", pc_o, 32'd32);
        chk1("mid_valid", valid_o, 1'b1);
        reset_i = 1'b1;
        #1;
        chk1("mid_rst_req", imem_req_o, 1'b0);
        chk1("mid_rst_valid", valid_o, 1'b0);
        tick();
        reset_i = 1'b0;
        pend.delete();
        #1;
        chk1("mid_post_valid", valid_o, 1'b0);
        chk("mid_post_addr", imem_addr_o, 32'h0);
        chk("mid_post_out", 32'(dut.outstanding_reg), 32'd0);
        chk("mid_post_disc", 32'(dut.discard_reg), 32'd0);
        chk("mid_post_pc", pc_o, 32'h0);
        chk("mid_post_src", pc_src_o, 32'h4);

        // Redirect with two responses outstanding
        auto_rsp   = 1'b0;
        imem_gnt_i = 1'b1;
        ready_i    = 1'b1;
        tick();
        tick();
        chk("rd_out", 32'(dut.outstanding_reg), 32'd2);
        imem_gnt_i  = 1'b0;
        pc_select_i = 1'b1;
        pc_branch_i = 32'h0000_0102;
        #1;
        chk1("rd_req_sel", imem_req_o, 1'b0);
        chk1("rd_valid_sel", valid_o, 1'b0);
        tick();
        pc_select_i = 1'b0;
        chk("rd_disc", 32'(dut.discard_reg), 32'd2);
        chk("rd_addr", imem_addr_o, 32'h0000_0100);
        auto_rsp   = 1'b1;
        imem_gnt_i = 1'b1;
        tick();
        chk1("rd_t1_valid", valid_o, 1'b0);
        tick();
        chk1("rd_t2_valid", valid_o, 1'b0);
        chk("rd_t2_disc", 32'(dut.discard_reg), 32'd1);
        tick();
        chk1("rd_t3_valid", valid_o, 1'b0);
        chk("rd_t3_disc", 32'(dut.discard_reg), 32'd0);
        tick();
        chk1("rd_t4_valid", valid_o, 1'b1);
        chk("rd_t4_pc", pc_o, 32'h0000_0100);
        chk("rd_t4_instr", instruction_o, mem_word(32'h0000_0100));
        drain("rd");
        chk("rd_next_addr", imem_addr_o, 32'h0000_0110);
        chk("rd_last_pc", pc_o, 32'h0000_010C);

        // Redirect on the same edge as the first of two responses
        auto_rsp   = 1'b0;
        imem_gnt_i = 1'b1;
        tick();
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend[0]);
        pc_select_i   = 1'b1;
        pc_branch_i   = 32'h0000_0200;
        tick();
        pc_select_i = 1'b0;
        chk("same_disc", 32'(dut.discard_reg), 32'd1);
        chk("same_out", 32'(dut.outstanding_reg), 32'd1);
        chk("same_addr", imem_addr_o, 32'h0000_0200);
        auto_rsp   = 1'b1;
        imem_gnt_i = 1'b1;
        tick();
        chk1("same_t1_valid", valid_o, 1'b0);
        tick();
        chk1("same_t2_valid", valid_o, 1'b0);
        chk("same_t2_disc", 32'(dut.discard_reg), 32'd0);
        tick();
        chk1("same_t3_valid", valid_o, 1'b1);
        chk("same_t3_pc", pc_o, 32'h0000_0200);
        chk("same_t3_instr", instruction_o, mem_word(32'h0000_0200));
        drain("same");

        // Address wrap at the top of the space
        pc_select_i = 1'b1;
        pc_branch_i = 32'hFFFF_FFFC;
        tick();
        pc_select_i = 1'b0;
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        ready_i    = 1'b0;
        tick();
        imem_gnt_i = 1'b0;
        chk("wrap_next_addr", imem_addr_o, 32'h0);
        tick();
        chk1("wrap_valid", valid_o, 1'b1);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_src", pc_src_o, 32'h0);
        drain("wrap");
        chk("wrap_hold_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_hold_src", pc_src_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
